// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: widths, op class/op code encodings and the shared integer ALU function
package alu_exec_unit_pkg;
  localparam int VAL_W = 32;
  localparam int TAG_W = 4;
  localparam int OP_W  = 7;
  typedef enum logic [2:0] {
    OP_R_TYPE    = 3'd0,
    OP_I_TYPE    = 3'd1,
    OP_U_TYPE    = 3'd2,
    OP_JALR_TYPE = 3'd3,
    OP_B_TYPE    = 3'd4
  } op_class_e;
  localparam logic [OP_W-1:0] OP_ADD   = 7'h00;
  localparam logic [OP_W-1:0] OP_SUB   = 7'h01;
  localparam logic [OP_W-1:0] OP_SLL   = 7'h02;
  localparam logic [OP_W-1:0] OP_SLT   = 7'h03;
  localparam logic [OP_W-1:0] OP_SLTU  = 7'h04;
  localparam logic [OP_W-1:0] OP_XOR   = 7'h05;
  localparam logic [OP_W-1:0] OP_SRL   = 7'h06;
  localparam logic [OP_W-1:0] OP_SRA   = 7'h07;
  localparam logic [OP_W-1:0] OP_OR    = 7'h08;
  localparam logic [OP_W-1:0] OP_AND   = 7'h09;
  localparam logic [OP_W-1:0] OP_ADDI  = 7'h10;
  localparam logic [OP_W-1:0] OP_SLLI  = 7'h12;
  localparam logic [OP_W-1:0] OP_SLTI  = 7'h13;
  localparam logic [OP_W-1:0] OP_SLTIU = 7'h14;
  localparam logic [OP_W-1:0] OP_XORI  = 7'h15;
  localparam logic [OP_W-1:0] OP_SRLI  = 7'h16;
  localparam logic [OP_W-1:0] OP_SRAI  = 7'h17;
  localparam logic [OP_W-1:0] OP_ORI   = 7'h18;
  localparam logic [OP_W-1:0] OP_ANDI  = 7'h19;
  localparam logic [OP_W-1:0] OP_LUI   = 7'h20;
  localparam logic [OP_W-1:0] OP_AUIPC = 7'h21;
  localparam logic [OP_W-1:0] OP_JAL   = 7'h22;
  localparam logic [OP_W-1:0] OP_JALR  = 7'h30;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'h40;
  localparam logic [OP_W-1:0] OP_BNE   = 7'h41;
  localparam logic [OP_W-1:0] OP_BLT   = 7'h44;
  localparam logic [OP_W-1:0] OP_BGE   = 7'h45;
  localparam logic [OP_W-1:0] OP_BLTU  = 7'h46;
  localparam logic [OP_W-1:0] OP_BGEU  = 7'h47;
  // Returns {known, value}; sub-function shared by register and immediate classes
  function automatic logic [VAL_W:0] alu_fn(input logic [3:0] f, input logic [VAL_W-1:0] a, input logic [VAL_W-1:0] b);
    case (f)
      4'h0: return {1'b1, a + b};
      4'h1: return {1'b1, a - b};
      4'h2: return {1'b1, a << b[4:0]};
      4'h3: return {1'b1, {(VAL_W-1){1'b0}}, $signed(a) < $signed(b)};
      4'h4: return {1'b1, {(VAL_W-1){1'b0}}, a < b};
      4'h5: return {1'b1, a ^ b};
      4'h6: return {1'b1, a >> b[4:0]};
      4'h7: return {1'b1, $signed(a) >>> b[4:0]};
      4'h8: return {1'b1, a | b};
      4'h9: return {1'b1, a & b};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/alu_exec_unit_core.sv
// alu_core: combinational result, redirect and next-PC for one RV32I op
module alu_core
  import alu_exec_unit_pkg::*;
(
  input  logic [OP_W-1:0]  op_type,
  input  logic [VAL_W-1:0] val1,
  input  logic [VAL_W-1:0] val2,
  input  logic [VAL_W-1:0] imm,
  input  logic [VAL_W-1:0] pc_in,
  output logic [VAL_W-1:0] result,
  output logic             redirect,
  output logic [VAL_W-1:0] next_pc
);
  op_class_e      cls;
  logic [3:0]     f;
  logic [VAL_W:0] alu;
  logic           taken;
  logic           br_ok;
  assign cls = op_class_e'(op_type[6:4]);
  assign f   = op_type[3:0];
  assign alu = alu_fn(f, val1, val2);
  always_comb begin
    taken = 1'b0;
    br_ok = 1'b1;
    case (f)
      4'h0: taken = val1 == val2;
      4'h1: taken = val1 != val2;
      4'h4: taken = $signed(val1) < $signed(val2);
      4'h5: taken = $signed(val1) >= $signed(val2);
      4'h6: taken = val1 < val2;
      4'h7: taken = val1 >= val2;
      default: br_ok = 1'b0;
    endcase
  end
  always_comb begin
    result   = '0;
    redirect = 1'b0;
    next_pc  = '0;
    case (cls)
      OP_R_TYPE: result = alu[VAL_W] ? alu[VAL_W-1:0] : '0;
      OP_I_TYPE: result = (alu[VAL_W] && f != 4'h1) ? alu[VAL_W-1:0] : '0;
      OP_U_TYPE: result = f == 4'h0 ? val1 : (f == 4'h1 || f == 4'h2) ? val1 + pc_in : '0;
      OP_JALR_TYPE: if (f == 4'h0) begin
        result   = pc_in + VAL_W'(4);
        redirect = 1'b1;
        next_pc  = (val1 + imm) & ~VAL_W'(1);
      end
      OP_B_TYPE: if (br_ok) begin
        result   = {{(VAL_W-1){1'b0}}, taken};
        redirect = 1'b1;
        next_pc  = taken ? pc_in + imm : pc_in + VAL_W'(4);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: one-cycle registered execute stage driving the CDB and fetch redirect
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             execute,
  input  logic [OP_W-1:0]  op_type,
  input  logic [VAL_W-1:0] val1,
  input  logic [VAL_W-1:0] val2,
  input  logic [VAL_W-1:0] imm,
  input  logic [VAL_W-1:0] pc_in,
  input  logic [TAG_W-1:0] entry,
  output logic             aluReady,
  output logic [TAG_W-1:0] entry_out,
  output logic [VAL_W-1:0] val_out,
  output logic             alu2if_con,
  output logic [VAL_W-1:0] alu2if_pc
);
  logic [VAL_W-1:0] result;
  logic             redirect;
  logic [VAL_W-1:0] next_pc;
  logic             fire_d;
  logic             ready_q;
  logic             con_q;
  logic [TAG_W-1:0] entry_q;
  logic [VAL_W-1:0] val_q;
  logic [VAL_W-1:0] pc_q;
  alu_core u_core (
    .op_type (op_type),
    .val1    (val1),
    .val2    (val2),
    .imm     (imm),
    .pc_in   (pc_in),
    .result  (result),
    .redirect(redirect),
    .next_pc (next_pc)
  );
  assign fire_d = execute & ~flush;
  // Payload holds between ops; the redirect PC only moves on ops that redirect
  always_ff @(posedge clk) begin
    if (rst_in) begin
      ready_q <= 1'b0;
      con_q   <= 1'b0;
      entry_q <= '0;
      val_q   <= '0;
      pc_q    <= '0;
    end else if (rdy_in) begin
      ready_q <= fire_d;
      con_q   <= fire_d & redirect;
      if (fire_d) begin
        entry_q <= entry;
        val_q   <= result;
      end
      if (fire_d && redirect) pc_q <= next_pc;
    end
  end
  assign aluReady   = ready_q;
  assign alu2if_con = con_q;
  assign entry_out  = entry_q;
  assign val_out    = val_q;
  assign alu2if_pc  = pc_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and random ops checked against a spec-level model every cycle
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;
  logic             clk = 1'b0;
  logic             rst_in, rdy_in, flush, execute;
  logic [OP_W-1:0]  op_type;
  logic [VAL_W-1:0] val1, val2, imm, pc_in;
  logic [TAG_W-1:0] entry;
  logic             aluReady, alu2if_con;
  logic [TAG_W-1:0] entry_out;
  logic [VAL_W-1:0] val_out, alu2if_pc;
  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;
  logic             m_rdy = 1'b0, m_con = 1'b0;
  logic [TAG_W-1:0] m_entry = '0;
  logic [VAL_W-1:0] m_val = '0, m_pc = '0;
  always #5 clk = ~clk;
  alu_exec_unit dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .execute(execute),
    .op_type(op_type), .val1(val1), .val2(val2), .imm(imm), .pc_in(pc_in), .entry(entry),
    .aluReady(aluReady), .entry_out(entry_out), .val_out(val_out),
    .alu2if_con(alu2if_con), .alu2if_pc(alu2if_pc)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Spec-level reference: {redirect, next_pc, value}
  function automatic logic [64:0] ref_op(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] im, input logic [31:0] pc);
    logic t;
    t = 1'b0;
    case (op)
      OP_ADD, OP_ADDI:   return {33'b0, a + b};
      OP_SUB:            return {33'b0, a - b};
      OP_SLL, OP_SLLI:   return {33'b0, a << b[4:0]};
      OP_SLT, OP_SLTI:   return {33'b0, 31'b0, $signed(a) < $signed(b)};
      OP_SLTU, OP_SLTIU: return {33'b0, 31'b0, a < b};
      OP_XOR, OP_XORI:   return {33'b0, a ^ b};
      OP_SRL, OP_SRLI:   return {33'b0, a >> b[4:0]};
      OP_SRA, OP_SRAI:   return {33'b0, $signed(a) >>> b[4:0]};
      OP_OR, OP_ORI:     return {33'b0, a | b};
      OP_AND, OP_ANDI:   return {33'b0, a & b};
      OP_LUI:            return {33'b0, a};
      OP_AUIPC, OP_JAL:  return {33'b0, a + pc};
      OP_JALR:           return {1'b1, (a + im) & 32'hFFFF_FFFE, pc + 32'd4};
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        if (op == OP_BEQ)  t = a == b;
        if (op == OP_BNE)  t = a != b;
        if (op == OP_BLT)  t = $signed(a) < $signed(b);
        if (op == OP_BGE)  t = $signed(a) >= $signed(b);
        if (op == OP_BLTU) t = a < b;
        if (op == OP_BGEU) t = a >= b;
        return {1'b1, t ? pc + im : pc + 32'd4, 31'b0, t};
      end
      default: return '0;
    endcase
  endfunction
  always @(posedge clk) begin
    logic [64:0] r;
    if (rst_in) begin
      m_rdy = 1'b0; m_con = 1'b0; m_entry = '0; m_val = '0; m_pc = '0;
    end else if (rdy_in) begin
      if (execute && !flush) begin
        r = ref_op(op_type, val1, val2, imm, pc_in);
        m_rdy = 1'b1; m_entry = entry; m_val = r[31:0]; m_con = r[64];
        if (r[64]) m_pc = r[63:32];
      end else begin
        m_rdy = 1'b0; m_con = 1'b0;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    check("cmp_ready", {31'b0, aluReady}, {31'b0, m_rdy});
    check("cmp_entry", {28'b0, entry_out}, {28'b0, m_entry});
    check("cmp_val", val_out, m_val);
    check("cmp_con", {31'b0, alu2if_con}, {31'b0, m_con});
    if (m_con) check("cmp_pc", alu2if_pc, m_pc);
  end
  task automatic issue(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [31:0] pc, input logic [3:0] tag, input logic ex = 1'b1,
                       input logic fl = 1'b0, input logic rd = 1'b1);
    op_type = op; val1 = a; val2 = b; imm = im; pc_in = pc; entry = tag;
    execute = ex; flush = fl; rdy_in = rd;
    @(negedge clk);
  endtask
  task automatic idle();
    issue(OP_ADD, 0, 0, 0, 0, 0, 1'b0);
  endtask
  logic [6:0] ops [30];
  initial begin
    ops = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
            OP_ADDI, OP_SLLI, OP_SLTI, OP_SLTIU, OP_XORI, OP_SRLI, OP_SRAI, OP_ORI, OP_ANDI,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, 7'h11};
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; execute = 1'b0;
    op_type = '0; val1 = '0; val2 = '0; imm = '0; pc_in = '0; entry = '0;
    @(negedge clk); @(negedge clk);
    check("rst_ready", {31'b0, aluReady}, 32'd0);
    check("rst_entry", {28'b0, entry_out}, 32'd0);
    check("rst_val", val_out, 32'd0);
    check("rst_con", {31'b0, alu2if_con}, 32'd0);
    check("rst_pc", alu2if_pc, 32'd0);
    rst_in = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("idle_ready", {31'b0, aluReady}, 32'd0);
    end
    issue(OP_ADD, 32'hFFFF_FFFF, 32'd2, 0, 0, 4'd5);
    check("add_ready", {31'b0, aluReady}, 32'd1);
    check("add_entry", {28'b0, entry_out}, 32'd5);
    check("add_val", val_out, 32'd1);
    idle();
    check("add_drop", {31'b0, aluReady}, 32'd0);
    issue(OP_SRA, 32'h8000_0000, 32'h24, 0, 0, 4'd6);
    check("sra_val", val_out, 32'hF800_0000);
    issue(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 0, 0, 4'd7);
    check("sltu_val", val_out, 32'd1);
    issue(OP_BLT, 32'hFFFF_FFFF, 32'd0, 32'h40, 32'h100, 4'd8);
    check("blt_con", {31'b0, alu2if_con}, 32'd1);
    check("blt_pc", alu2if_pc, 32'h140);
    check("blt_val", val_out, 32'd1);
    issue(OP_BGEU, 32'hFFFF_FFFF, 32'd0, 32'h40, 32'h100, 4'd9);
    check("bgeu_val", val_out, 32'd1);
    check("bgeu_pc", alu2if_pc, 32'h140);
    issue(OP_JALR, 32'h1003, 32'd0, 32'd4, 32'h200, 4'd10);
    check("jalr_pc", alu2if_pc, 32'h1006);
    check("jalr_val", val_out, 32'h204);
    check("jalr_con", {31'b0, alu2if_con}, 32'd1);
    issue(OP_BEQ, 32'd3, 32'd4, 32'h80, 32'h300, 4'd11);
    check("beq_nt_pc", alu2if_pc, 32'h304);
    issue(7'h7F, 32'd3, 32'd4, 0, 0, 4'd12);
    check("bad_ready", {31'b0, aluReady}, 32'd1);
    check("bad_val", val_out, 32'd0);
    check("bad_con", {31'b0, alu2if_con}, 32'd0);
    issue(OP_ADD, 32'd1, 32'd1, 0, 0, 4'd9, 1'b1, 1'b1);
    check("flush_ready", {31'b0, aluReady}, 32'd0);
    issue(OP_ADD, 32'd3, 32'd4, 0, 0, 4'd10);
    check("rdy_first", val_out, 32'd7);
    for (int i = 0; i < 3; i++) begin
      issue(OP_SUB, 32'd9, 32'd1, 0, 0, 4'd11, 1'b1, 1'b0, 1'b0);
      check("rdy_hold", {31'b0, aluReady}, 32'd1);
      check("rdy_val", val_out, 32'd7);
    end
    idle();
    check("rdy_clear", {31'b0, aluReady}, 32'd0);
    for (int i = 0; i < 200; i++)
      issue(ops[$urandom_range(0, 29)], $urandom, $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
            4'($urandom_range(1, 15)), $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) != 0);
    rst_in = 1'b1;
    issue(OP_ADD, 32'd5, 32'd6, 0, 0, 4'd3);
    check("rst_mid_ready", {31'b0, aluReady}, 32'd0);
    check("rst_mid_val", val_out, 32'd0);
    rst_in = 1'b0;
    idle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
